// File: rtl/day_12_pkg.sv
// rtl/day_12_pkg.sv - shared types and constants for the day-12 sequence detector slice
package day_12_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int SEQ_WIDTH = 12;
    // Target sequence shared by the detector, this feeder and the benches.
    localparam logic [SEQ_WIDTH-1:0] SEQ_PATTERN = 12'b1110_1101_1011;

endpackage

// File: rtl/day_12_seq_serializer.sv
// rtl/day_12_seq_serializer.sv - parallel-to-serial feeder for the day-12 detector x_i input
module day_12_seq_serializer
    import day_12_pkg::*;
#(
    parameter int WIDTH     = SEQ_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             abort_i,
    output logic             x_o,
    output logic             bit_valid_o,
    output logic             last_o
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] sreg;
    logic             word_end;
    logic             accept;

    assign word_end = (state == SHIFT) && (bit_cnt == '0);
    assign accept   = valid_i & ready_o;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort_i) begin
            state_nxt = IDLE;
        end else if (accept) begin
            state_nxt = SHIFT;
        end else if (word_end) begin
            state_nxt = IDLE;
        end
    end

    // Accepting on the last-bit cycle is what lets words stream with no gap.
    always_comb begin
        ready_o = reset & ~abort_i & ((state == IDLE) | word_end);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sreg        <= '0;
            bit_cnt     <= '0;
            x_o         <= IDLE_BIT;
            bit_valid_o <= 1'b0;
            last_o      <= 1'b0;
        end else if (abort_i) begin
            bit_cnt     <= '0;
            x_o         <= IDLE_BIT;
            bit_valid_o <= 1'b0;
            last_o      <= 1'b0;
        end else if (accept) begin
            // The first bit goes straight to x_o; sreg keeps the rest lined up at the shift end.
            sreg        <= MSB_FIRST ? (data_i << 1) : (data_i >> 1);
            x_o         <= MSB_FIRST ? data_i[WIDTH-1] : data_i[0];
            bit_cnt     <= CNT_W'(WIDTH - 1);
            bit_valid_o <= 1'b1;
            last_o      <= 1'b0;
        end else if ((state == SHIFT) && (bit_cnt != '0)) begin
            sreg        <= MSB_FIRST ? (sreg << 1) : (sreg >> 1);
            x_o         <= MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
            bit_cnt     <= bit_cnt - 1'b1;
            last_o      <= (bit_cnt == CNT_W'(1));
        end else if (word_end) begin
            x_o         <= IDLE_BIT;
            bit_valid_o <= 1'b0;
            last_o      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_day_12_seq_serializer.sv
// tb/tb_day_12_seq_serializer.sv - randomized bench for day_12_seq_serializer against a bit-queue model
module tb_day_12_seq_serializer;
    import day_12_pkg::*;

    logic        clk;
    logic        reset;
    logic [11:0] data_i;
    logic        valid_i;
    logic        abort_i;
    logic        ready_m, x_m, bv_m, last_m;
    logic        ready_l, x_l, bv_l, last_l;

    int errors = 0;
    int checks = 0;

    bit   qm[$];
    bit   ql[$];
    logic m_x_m, m_x_l, m_bv, m_last;
    logic accepted;
    logic pend_valid;
    logic [11:0] pend_data;

    day_12_seq_serializer #(.WIDTH(12), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
        .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_m),
        .abort_i(abort_i), .x_o(x_m), .bit_valid_o(bv_m), .last_o(last_m)
    );

    day_12_seq_serializer #(.WIDTH(12), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .data_i(data_i), .valid_i(valid_i), .ready_o(ready_l),
        .abort_i(abort_i), .x_o(x_l), .bit_valid_o(bv_l), .last_o(last_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: apply inputs, check ready, advance the model, check registered outputs.
    task automatic cycle(input logic rst, input logic v, input logic ab, input logic [11:0] d);
        logic exp_ready;
        reset   = rst;
        valid_i = v;
        abort_i = ab;
        data_i  = d;
        #1;
        exp_ready = rst && !ab && (!m_bv || qm.size() == 0);
        check("ready_msb", 32'(ready_m), 32'(exp_ready));
        check("ready_lsb", 32'(ready_l), 32'(exp_ready));
        accepted = exp_ready && v;
        @(posedge clk);
        if (!rst || ab) begin
            qm.delete(); ql.delete();
            m_x_m = 1'b0; m_x_l = 1'b0; m_bv = 1'b0; m_last = 1'b0;
        end else if (accepted) begin
            qm.delete(); ql.delete();
            for (int i = 11; i >= 0; i--) qm.push_back(d[i]);
            for (int i = 0; i < 12; i++) ql.push_back(d[i]);
            m_x_m = qm.pop_front(); m_x_l = ql.pop_front();
            m_bv = 1'b1; m_last = (qm.size() == 0);
        end else if (m_bv && qm.size() > 0) begin
            m_x_m = qm.pop_front(); m_x_l = ql.pop_front();
            m_last = (qm.size() == 0);
        end else begin
            m_x_m = 1'b0; m_x_l = 1'b0; m_bv = 1'b0; m_last = 1'b0;
        end
        #1;
        check("x_msb", 32'(x_m), 32'(m_x_m));
        check("x_lsb", 32'(x_l), 32'(m_x_l));
        check("bit_valid_msb", 32'(bv_m), 32'(m_bv));
        check("bit_valid_lsb", 32'(bv_l), 32'(m_bv));
        check("last_msb", 32'(last_m), 32'(m_last));
        check("last_lsb", 32'(last_l), 32'(m_last));
    endtask

    // Producer that holds valid/data until the word is taken, bounded by a cycle budget.
    task automatic send_words(input logic [11:0] w0, input logic [11:0] w1, input int n);
        int idx = 0;
        int budget = 100;
        while (idx < n && budget > 0) begin
            cycle(1'b1, 1'b1, 1'b0, (idx == 0) ? w0 : w1);
            if (accepted) idx++;
            budget--;
        end
        check("send_budget", 32'(idx), 32'(n));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 12'($urandom));
    endtask

    initial begin
        int vcnt;
        m_x_m = 1'b0; m_x_l = 1'b0; m_bv = 1'b0; m_last = 1'b0;
        accepted = 1'b0;
        pend_valid = 1'b0;
        pend_data = '0;

        cycle(1'b0, 1'b1, 1'b0, SEQ_PATTERN);
        cycle(1'b0, 1'b0, 1'b0, 12'h000);

        // Single word, with an explicit count of valid bits.
        send_words(SEQ_PATTERN, 12'h000, 1);
        vcnt = 1;
        for (int i = 0; i < 13; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 12'h000);
            if (bv_m) vcnt++;
        end
        check("word_len", 32'(vcnt), 32'd12);

        send_words(12'hEDB, 12'hF00, 2);
        idle(14);
        send_words(12'hEDB, 12'hABC, 2);
        idle(14);

        // Abort while the 5th bit is on x_o, with valid held high during the abort.
        send_words(12'hEDB, 12'h000, 1);
        idle(4);
        cycle(1'b1, 1'b1, 1'b1, 12'h5A5);
        send_words(12'h5A5, 12'h000, 1);
        idle(13);

        // Reset in the middle of a word.
        send_words(12'hEDB, 12'h000, 1);
        idle(6);
        cycle(1'b0, 1'b0, 1'b0, 12'h000);
        idle(14);

        send_words(12'h001, 12'h000, 1);
        idle(13);

        for (int i = 0; i < 3000; i++) begin
            logic r, a;
            if (!pend_valid && ($urandom_range(0, 3) != 0)) begin
                pend_valid = 1'b1;
                pend_data  = 12'($urandom);
            end
            r = ($urandom_range(0, 199) != 0);
            a = ($urandom_range(0, 59) == 0);
            cycle(r, pend_valid, a, pend_data);
            if (accepted) pend_valid = 1'b0;
        end
        idle(14);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/day_12_seq_serializer.md
Name: day_12_seq_serializer

Overview:
Upstream feeder for the day-12 sequence detector. It accepts parallel words over a valid/ready handshake and shifts them out one bit per clock onto the detector's serial input x_i. Back-to-back words stream with no idle gap, so patterns that straddle word boundaries reach the detector intact. A synchronous abort discards the word in flight.

Parameters:
WIDTH, 12, bits per word (>=2)
MSB_FIRST, 1, 1 = shift data_i[WIDTH-1] first; 0 = shift data_i[0] first
IDLE_BIT, 0, value driven on x_o when no bit is valid

Ports:
clk  input  1  single clock, rising edge
reset  input  1  synchronous, active-low; reset = 0 at a rising edge resets the block
data_i  input  WIDTH  parallel word to serialize
valid_i  input  1  data_i valid
ready_o  output  1  block can accept a word this cycle (combinational)
abort_i  input  1  drop the word in flight; return to IDLE
x_o  output  1  serial bit to the detector's x_i (registered)
bit_valid_o  output  1  x_o carries a word bit this cycle (registered)
last_o  output  1  x_o is the final bit of the current word (registered)

Behaviour:
- Reset (reset = 0 at an edge): state = IDLE, bit_cnt = 0, x_o = IDLE_BIT, bit_valid_o = 0, last_o = 0. ready_o = 0 while reset is low.
- States: IDLE, SHIFT. A down-counter bit_cnt of width $clog2(WIDTH) holds the number of bits remaining after the current one.
- ready_o = reset & ~abort_i & (state == IDLE | (state == SHIFT & bit_cnt == 0)).
- Accept: valid_i & ready_o at an edge.
  - Load the shift register with data_i.
  - At that same edge, x_o takes the first bit, bit_valid_o goes to 1, bit_cnt loads WIDTH-1, state goes to SHIFT.
  - Latency from acceptance to first bit on x_o: 1 edge.
- In SHIFT with bit_cnt > 0: each edge advances one bit and decrements bit_cnt.
  - Bit order is MSB-first or LSB-first per MSB_FIRST.
  - last_o = 1 exactly while bit_cnt == 0.
- End of word (SHIFT, bit_cnt == 0):
  - If a word is accepted at this edge, it loads immediately. There is no gap, and bit_valid_o stays 1.
  - Otherwise: state goes to IDLE, x_o = IDLE_BIT, bit_valid_o = 0, last_o = 0.
- A word is exactly WIDTH consecutive bit_valid_o cycles.
- valid_i while busy (SHIFT, bit_cnt > 0): ready_o = 0 and the word is not taken. The producer holds data_i and valid_i.
- abort_i = 1 at an edge (any state):
  - Next state IDLE; x_o = IDLE_BIT, bit_valid_o = 0, last_o = 0, bit_cnt = 0.
  - No word is accepted in that cycle, because ready_o is forced low.
- Reset overrides abort and accept. A reset mid-word discards the remaining bits.
- valid_i without ready_o has no effect. data_i is sampled only at acceptance.

Decomposition:
- Shared package day_12_pkg holds:
  - the state enum (IDLE, SHIFT);
  - localparam SEQ_WIDTH = 12;
  - localparam SEQ_PATTERN = 12'b1110_1101_1011, the target sequence shared with the detector and the benches.
- No sub-module. The shift register, counter and two-state FSM sit in one module.

Test Plan:
- Reset low for 2 edges, then high; send data_i = 12'hEDB, valid_i = 1 for one accepted cycle -> x_o over 12 edges = 1,1,1,0,1,1,0,1,1,0,1,1; bit_valid_o = 1 for exactly 12 cycles; last_o only on the 12th; then x_o = 0 and ready_o = 1.
- Two words 12'hEDB then 12'hF00, with valid_i held high -> 24 contiguous valid bits and no gap; ready_o pulses only during each last bit; the second word's first bit follows the first word's last bit on the next edge.
- valid_i held high with 12'hABC from the cycle after the first acceptance -> ready_o = 0 for 11 cycles; 12'hABC is accepted on the last-bit cycle; its bits follow with no gap.
- abort_i = 1 while the 5th bit is on x_o -> at the next edge x_o = 0, bit_valid_o = 0, state IDLE; ready_o = 0 during the abort cycle and 1 after it; a new word then serializes from its first bit.
- reset = 0 asserted mid-word (bit 7) -> at the next edge all outputs take reset values; after release, no residual bits appear.
- MSB_FIRST = 0 with data_i = 12'h001 -> x_o = 1 on the first bit, then 0 for the remaining 11 bits.
